comm_frame_rx: RTL and testbench



---
 rtl/comm_frame_rx_if.sv | 29 ++
 rtl/comm_frame_rx.sv | 166 ++++++++++++++++
 tb/tb_comm_frame_rx.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/comm_frame_rx_if.sv
// Bundle of the UART-facing and consumer-facing signals of the command-frame receiver.
// rx_rdy/clr_rx_rdy: a byte is valid while rx_rdy is high and is consumed in the cycle clr_rx_rdy is high.
// cmd_rdy/clr_cmd_rdy and send_resp/trmt/tx_done/resp_sent form the other handshakes.
interface comm_frame_rx_if;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        resp_sent;
    logic        frm_err;

    modport slave (
        input  rx_rdy, rx_data, clr_cmd_rdy, send_resp, resp, tx_done,
        output clr_rx_rdy, cmd, data, cmd_rdy, trmt, tx_data, resp_sent, frm_err
    );

    modport master (
        output rx_rdy, rx_data, clr_cmd_rdy, send_resp, resp, tx_done,
        input  clr_rx_rdy, cmd, data, cmd_rdy, trmt, tx_data, resp_sent, frm_err
    );
endinterface

// File: rtl/comm_frame_rx.sv
// Assembles three-byte command frames from the UART receiver and sequences
// one-byte responses to the UART transmitter through a one-deep pending buffer.
module comm_frame_rx #(
    parameter int TO_CYCLES = 1_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    comm_frame_rx_if.slave      bus,
    output logic [1:0]          rx_state_o,
    output logic                tx_state_o
);

    localparam int CW = (TO_CYCLES > 2) ? $clog2(TO_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TO_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_H = 2'd1,
        WAIT_L = 2'd2
    } rx_state_t;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_BUSY = 1'b1
    } tx_state_t;

    rx_state_t   rx_state_q;
    logic [7:0]  cmd_hold_q;
    logic [7:0]  hi_hold_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [7:0]  cmd_q;
    logic [15:0] data_q;
    logic        cmd_rdy_q;
    logic        timeout;

    tx_state_t   tx_state_q;
    logic [7:0]  tx_data_q;
    logic        trmt_q;
    logic        resp_sent_q;
    logic [7:0]  pend_q;
    logic        pend_vld_q;

    // A byte arriving in the last counted cycle wins over the timeout.
    assign timeout = (rx_state_q != IDLE) && !bus.rx_rdy && (cnt_q == TO_LAST);
    assign cnt_d   = cnt_q + 1'b1;

    assign bus.clr_rx_rdy = bus.rx_rdy;
    assign bus.frm_err    = timeout;
    assign bus.cmd        = cmd_q;
    assign bus.data       = data_q;
    assign bus.cmd_rdy    = cmd_rdy_q;
    assign bus.trmt       = trmt_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.resp_sent  = resp_sent_q;
    assign rx_state_o     = rx_state_q;
    assign tx_state_o     = tx_state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= IDLE;
            cmd_hold_q <= '0;
            hi_hold_q  <= '0;
            cnt_q      <= '0;
            cmd_q      <= '0;
            data_q     <= '0;
            cmd_rdy_q  <= 1'b0;
        end else begin
            if (bus.clr_cmd_rdy) begin
                cmd_rdy_q <= 1'b0;
            end
            case (rx_state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (bus.rx_rdy) begin
                        cmd_hold_q <= bus.rx_data;
                        rx_state_q <= WAIT_H;
                    end
                end
                WAIT_H: begin
                    if (bus.rx_rdy) begin
                        hi_hold_q  <= bus.rx_data;
                        cnt_q      <= '0;
                        rx_state_q <= WAIT_L;
                    end else if (timeout) begin
                        cmd_hold_q <= '0;
                        hi_hold_q  <= '0;
                        cnt_q      <= '0;
                        rx_state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                WAIT_L: begin
                    if (bus.rx_rdy) begin
                        // Completion overrides a coincident clr_cmd_rdy above.
                        cmd_q      <= cmd_hold_q;
                        data_q     <= {hi_hold_q, bus.rx_data};
                        cmd_rdy_q  <= 1'b1;
                        cnt_q      <= '0;
                        rx_state_q <= IDLE;
                    end else if (timeout) begin
                        cmd_hold_q <= '0;
                        hi_hold_q  <= '0;
                        cnt_q      <= '0;
                        rx_state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    cnt_q      <= '0;
                    rx_state_q <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q  <= TX_IDLE;
            tx_data_q   <= '0;
            trmt_q      <= 1'b0;
            resp_sent_q <= 1'b0;
            pend_q      <= '0;
            pend_vld_q  <= 1'b0;
        end else begin
            trmt_q      <= 1'b0;
            resp_sent_q <= 1'b0;
            case (tx_state_q)
                TX_IDLE: begin
                    if (bus.send_resp) begin
                        tx_data_q  <= bus.resp;
                        trmt_q     <= 1'b1;
                        tx_state_q <= TX_BUSY;
                    end
                end
                TX_BUSY: begin
                    if (bus.tx_done) begin
                        resp_sent_q <= 1'b1;
                        if (pend_vld_q) begin
                            tx_data_q <= pend_q;
                            trmt_q    <= 1'b1;
                            if (bus.send_resp) begin
                                pend_q <= bus.resp;
                            end else begin
                                pend_vld_q <= 1'b0;
                            end
                        end else if (bus.send_resp) begin
                            // Request racing tx_done with an empty buffer goes straight out.
                            tx_data_q <= bus.resp;
                            trmt_q    <= 1'b1;
                        end else begin
                            tx_state_q <= TX_IDLE;
                        end
                    end else if (bus.send_resp) begin
                        pend_q     <= bus.resp;
                        pend_vld_q <= 1'b1;
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_comm_frame_rx.sv
// Self-checking bench for comm_frame_rx: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a queue model.
module tb_comm_frame_rx;

    localparam int TO = 1000;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    comm_frame_rx_if bus ();
    logic [1:0] rx_state;
    logic       tx_state;

    comm_frame_rx #(.TO_CYCLES(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .rx_state_o (rx_state),
        .tx_state_o (tx_state)
    );

    int checks = 0;
    int errors = 0;
    int clr_cnt = 0;
    int rs_cnt = 0;

    // ---------------- behavioural model ----------------
    logic [7:0]  part_q[$];
    int          gap = 0;
    logic [7:0]  m_cmd = '0;
    logic [15:0] m_data = '0;
    logic        m_rdy = 1'b0;
    logic        m_busy = 1'b0;
    logic [7:0]  m_cur = '0;
    logic [7:0]  pend_q[$];
    logic        m_trmt = 1'b0;
    logic        m_rs = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            part_q.delete();
            pend_q.delete();
            gap    = 0;
            m_cmd  = '0;
            m_data = '0;
            m_rdy  = 1'b0;
            m_busy = 1'b0;
            m_cur  = '0;
            m_trmt = 1'b0;
            m_rs   = 1'b0;
        end else begin
            if (bus.clr_cmd_rdy) m_rdy = 1'b0;
            if (bus.rx_rdy) begin
                part_q.push_back(bus.rx_data);
                gap = 0;
                if (part_q.size() == 3) begin
                    m_cmd  = part_q[0];
                    m_data = {part_q[1], part_q[2]};
                    m_rdy  = 1'b1;
                    part_q.delete();
                end
            end else if (part_q.size() != 0) begin
                if (gap == TO - 1) begin
                    part_q.delete();
                    gap = 0;
                end else begin
                    gap++;
                end
            end
            m_trmt = 1'b0;
            m_rs   = 1'b0;
            if (!m_busy) begin
                if (bus.send_resp) begin
                    m_cur  = bus.resp;
                    m_busy = 1'b1;
                    m_trmt = 1'b1;
                end
            end else if (bus.tx_done) begin
                m_rs = 1'b1;
                if (pend_q.size() != 0) begin
                    m_cur  = pend_q.pop_front();
                    m_trmt = 1'b1;
                    if (bus.send_resp) pend_q.push_back(bus.resp);
                end else if (bus.send_resp) begin
                    m_cur  = bus.resp;
                    m_trmt = 1'b1;
                end else begin
                    m_busy = 1'b0;
                end
            end else if (bus.send_resp) begin
                pend_q.delete();
                pend_q.push_back(bus.resp);
            end
        end
    end

    // ---------------- checking ----------------
    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        logic exp_frm;
        exp_frm = rst_n && (part_q.size() != 0) && (gap == TO - 1) && !bus.rx_rdy;
        cmp("cmd", bus.cmd, m_cmd);
        cmp("data", bus.data, m_data);
        cmp("cmd_rdy", bus.cmd_rdy, m_rdy);
        cmp("clr_rx_rdy", bus.clr_rx_rdy, bus.rx_rdy);
        cmp("frm_err", bus.frm_err, exp_frm);
        cmp("trmt", bus.trmt, m_trmt);
        cmp("tx_data", bus.tx_data, m_cur);
        cmp("resp_sent", bus.resp_sent, m_rs);
        if (bus.clr_rx_rdy === 1'b1) clr_cnt++;
        if (bus.resp_sent === 1'b1) rs_cnt++;
    endtask

    task automatic cyc();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_rdy  = 1'b1;
        bus.rx_data = b;
        cyc();
        bus.rx_rdy  = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        send_byte(a);
        idle(2);
        send_byte(b);
        idle(2);
        send_byte(c);
    endtask

    task automatic request(input logic [7:0] r);
        bus.resp      = r;
        bus.send_resp = 1'b1;
        cyc();
        bus.send_resp = 1'b0;
    endtask

    task automatic done_pulse();
        bus.tx_done = 1'b1;
        cyc();
        bus.tx_done = 1'b0;
    endtask

    initial begin
        int c0;
        int r0;
        int n;
        bus.rx_rdy      = 1'b0;
        bus.rx_data     = '0;
        bus.clr_cmd_rdy = 1'b0;
        bus.send_resp   = 1'b0;
        bus.resp        = '0;
        bus.tx_done     = 1'b0;
        #1 rst_n = 1'b0;
        idle(3);
        cmp("rst_cmd", bus.cmd, 8'h00);
        cmp("rst_data", bus.data, 16'h0000);
        cmp("rst_cmd_rdy", bus.cmd_rdy, 1'b0);
        cmp("rst_trmt", bus.trmt, 1'b0);
        cmp("rst_rx_state", rx_state, 2'd0);
        cmp("rst_tx_state", tx_state, 1'b0);
        rst_n = 1'b1;
        idle(3);

        // Frame with long gaps
        c0 = clr_cnt;
        send_byte(8'h06);
        idle(200);
        send_byte(8'h00);
        idle(200);
        cmp("t1_rdy_before", bus.cmd_rdy, 1'b0);
        send_byte(8'h00);
        cmp("t1_cmd_rdy", bus.cmd_rdy, 1'b1);
        cmp("t1_cmd", bus.cmd, 8'h06);
        cmp("t1_data", bus.data, 16'h0000);
        cmp("t1_clr_pulses", clr_cnt - c0, 3);

        // Overwrite while cmd_rdy high, clear coincident with completion
        send_frame(8'h05, 8'h01, 8'hFF);
        cmp("t2_first_data", bus.data, 16'h01FF);
        send_byte(8'h02);
        send_byte(8'h12);
        bus.clr_cmd_rdy = 1'b1;
        send_byte(8'h34);
        bus.clr_cmd_rdy = 1'b0;
        cmp("t2_cmd", bus.cmd, 8'h02);
        cmp("t2_data", bus.data, 16'h1234);
        cmp("t2_cmd_rdy", bus.cmd_rdy, 1'b1);
        bus.clr_cmd_rdy = 1'b1;
        cyc();
        bus.clr_cmd_rdy = 1'b0;
        cmp("t2_cleared", bus.cmd_rdy, 1'b0);

        // Timeout after two bytes
        send_byte(8'h05);
        send_byte(8'h01);
        n = -1;
        for (int i = 0; i < 2 * TO; i++) begin
            if (bus.frm_err === 1'b1) begin
                n = i;
                break;
            end
            cyc();
        end
        cmp("t3_frm_err_cycle", n, TO - 1);
        cyc();
        cmp("t3_frm_err_gone", bus.frm_err, 1'b0);
        cmp("t3_cmd_kept", bus.cmd, 8'h02);
        cmp("t3_data_kept", bus.data, 16'h1234);
        send_frame(8'h04, 8'hAB, 8'hCD);
        cmp("t3_cmd", bus.cmd, 8'h04);
        cmp("t3_data", bus.data, 16'hABCD);

        // Single response
        request(8'hA5);
        cmp("t4_trmt", bus.trmt, 1'b1);
        cmp("t4_tx_data", bus.tx_data, 8'hA5);
        idle(99);
        done_pulse();
        cmp("t4_resp_sent", bus.resp_sent, 1'b1);
        cyc();
        cmp("t4_resp_sent_low", bus.resp_sent, 1'b0);

        // Pending buffer overwrite
        r0 = rs_cnt;
        request(8'h11);
        idle(5);
        request(8'hA5);
        idle(3);
        request(8'h5A);
        idle(5);
        done_pulse();
        cmp("t5_trmt", bus.trmt, 1'b1);
        cmp("t5_tx_data", bus.tx_data, 8'h5A);
        idle(10);
        done_pulse();
        idle(3);
        cmp("t5_resp_sent_cnt", rs_cnt - r0, 2);
        cmp("t5_tx_idle", tx_state, 1'b0);

        // Reset mid-frame and mid-transmit
        send_byte(8'h05);
        request(8'h33);
        idle(3);
        rst_n = 1'b0;
        #1;
        cmp("t6_cmd", bus.cmd, 8'h00);
        cmp("t6_data", bus.data, 16'h0000);
        cmp("t6_cmd_rdy", bus.cmd_rdy, 1'b0);
        cmp("t6_tx_data", bus.tx_data, 8'h00);
        cmp("t6_rx_state", rx_state, 2'd0);
        cmp("t6_tx_state", tx_state, 1'b0);
        idle(2);
        rst_n = 1'b1;
        idle(2);
        send_frame(8'h06, 8'h00, 8'h00);
        cmp("t6_new_cmd", bus.cmd, 8'h06);
        cmp("t6_new_data", bus.data, 16'h0000);
        cmp("t6_new_rdy", bus.cmd_rdy, 1'b1);

        // Randomized traffic with receive stalls long enough to time out
        for (int blk = 0; blk < 4; blk++) begin
            for (int k = 0; k < 600; k++) begin
                bus.rx_rdy      = ($urandom_range(0, 3) == 0);
                bus.rx_data     = 8'($urandom);
                bus.clr_cmd_rdy = ($urandom_range(0, 7) == 0);
                bus.send_resp   = ($urandom_range(0, 9) == 0);
                bus.resp        = 8'($urandom);
                bus.tx_done     = ($urandom_range(0, 5) == 0);
                cyc();
            end
            bus.rx_rdy = 1'b0;
            for (int k = 0; k < TO + 5; k++) begin
                bus.clr_cmd_rdy = ($urandom_range(0, 7) == 0);
                bus.send_resp   = ($urandom_range(0, 9) == 0);
                bus.resp        = 8'($urandom);
                bus.tx_done     = ($urandom_range(0, 5) == 0);
                cyc();
            end
        end
        bus.clr_cmd_rdy = 1'b0;
        bus.send_resp   = 1'b0;
        bus.tx_done     = 1'b0;
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
